// File: rtl/fpu_cvt_wb_queue_pkg.sv
// Shared types and constants for the FP->int convert writeback queue.
// The converter latency is defined here so the tracker and converter cannot disagree.
package fpu_cvt_wb_queue_pkg;

    localparam int CVT_LAT_DEF   = 2;
    localparam int CVT_DEPTH_DEF = 4;
    localparam int CVT_REGW      = 9;
    localparam int CVT_IIW       = 10;

    typedef struct packed {
        logic [63:0]         data;
        logic [CVT_REGW-1:0] dst_reg;
        logic [CVT_IIW-1:0]  ii;
        logic                exc;
    } fifo_entry_t;

    typedef struct packed {
        logic                v;
        logic [CVT_REGW-1:0] dst_reg;
        logic [CVT_IIW-1:0]  ii;
    } trk_t;

    // Bit 64 of the converter result is the overflow/invalid flag.
    function automatic fifo_entry_t make_entry(input logic [64:0] res, input logic alt, input trk_t trk);
        fifo_entry_t e;
        e.data    = res[63:0];
        e.dst_reg = trk.dst_reg;
        e.ii      = trk.ii;
        e.exc     = res[64] | alt;
        return e;
    endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Generic synchronous circular-buffer FIFO: push/pop/flush, count, combinational head.
// Zero-latency head read; push at full is only legal together with a pop.
module fpu_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_pop;

    assign w_pop   = i_pop & (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Upstream credit accounting must keep a lone push off a full buffer.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst || i_flush)
        !(i_push && !w_pop && (r_count == FULL_CNT)));

endmodule

// File: rtl/fpu_cvt_wb_queue.sv
// FP->int convert writeback: tracks ops through the converter, queues results, drains to int WB.
// Issue-to-wb_valid is CVT_LAT+1 enabled cycles; wb_ready backpressure feeds the cvt_stall credit.
module fpu_cvt_wb_queue
    import fpu_cvt_wb_queue_pkg::*;
#(
    parameter int CVT_LAT = CVT_LAT_DEF,
    parameter int DEPTH   = CVT_DEPTH_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clk_en,
    input  logic                    i_cvt_issue,
    input  logic [CVT_REGW-1:0]     i_cvt_reg,
    input  logic [CVT_IIW-1:0]      i_cvt_ii,
    input  logic [64:0]             i_cvt_res,
    input  logic                    i_cvt_alt,
    input  logic                    i_flush,
    input  logic                    i_wb_ready,
    output logic                    o_wb_valid,
    output logic [63:0]             o_wb_data,
    output logic [CVT_REGW-1:0]     o_wb_reg,
    output logic [CVT_IIW-1:0]      o_wb_ii,
    output logic                    o_wb_exc,
    output logic                    o_cvt_stall,
    output logic [$clog2(DEPTH):0]  o_occ
);

    localparam int CW = $clog2(DEPTH + CVT_LAT + 2);

    trk_t                   r_trk [CVT_LAT];
    logic                   w_push;
    logic                   w_pop;
    fifo_entry_t            w_push_ent;
    fifo_entry_t            w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic [CW-1:0]          w_inflight;
    logic [CW-1:0]          w_credit_use;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            for (int i = 0; i < CVT_LAT; i++) begin
                r_trk[i] <= '0;
            end
        end else if (i_clk_en) begin
            r_trk[0] <= trk_t'{v: i_cvt_issue, dst_reg: i_cvt_reg, ii: i_cvt_ii};
            for (int i = 1; i < CVT_LAT; i++) begin
                r_trk[i] <= r_trk[i-1];
            end
        end
    end

    // The converter output lines up with the last tracking stage only on enabled cycles.
    assign w_push     = i_clk_en & r_trk[CVT_LAT-1].v;
    assign w_push_ent = make_entry(i_cvt_res, i_cvt_alt, r_trk[CVT_LAT-1]);
    assign w_pop      = o_wb_valid & i_wb_ready;

    fpu_wb_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_flush    (i_flush),
        .i_push     (w_push),
        .i_push_dat (w_push_ent),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_count)
    );

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < CVT_LAT; i++) begin
            w_inflight = w_inflight + CW'(r_trk[i].v);
        end
    end

    // Every queued or in-flight op holds a buffer slot; stall before they could exceed DEPTH.
    assign w_credit_use = CW'(w_count) + w_inflight + CW'(i_cvt_issue);
    assign o_cvt_stall  = (w_credit_use >= CW'(DEPTH));

    assign o_wb_valid = (w_count != '0);
    assign o_wb_data  = w_head.data;
    assign o_wb_reg   = w_head.dst_reg;
    assign o_wb_ii    = w_head.ii;
    assign o_wb_exc   = w_head.exc;
    assign o_occ      = w_count;

endmodule

// File: tb/tb_fpu_cvt_wb_queue.sv
// Bench for fpu_cvt_wb_queue: directed scenarios then random traffic against a queue-based model.
module tb_fpu_cvt_wb_queue;
    import fpu_cvt_wb_queue_pkg::*;

    localparam int LAT   = CVT_LAT_DEF;
    localparam int DEPTH = CVT_DEPTH_DEF;

    typedef struct {
        logic [CVT_REGW-1:0] rg;
        logic [CVT_IIW-1:0]  ii;
        int                  n;
    } op_t;

    typedef struct {
        logic [64:0] res;
        logic        alt;
    } plan_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   clk_en;
    logic                   cvt_issue;
    logic [CVT_REGW-1:0]    cvt_reg;
    logic [CVT_IIW-1:0]     cvt_ii;
    logic [64:0]            cvt_res;
    logic                   cvt_alt;
    logic                   flush;
    logic                   wb_ready;
    logic                   wb_valid;
    logic [63:0]            wb_data;
    logic [CVT_REGW-1:0]    wb_reg;
    logic [CVT_IIW-1:0]     wb_ii;
    logic                   wb_exc;
    logic                   cvt_stall;
    logic [$clog2(DEPTH):0] occ;

    fifo_entry_t exp_q[$];
    op_t         infl[$];
    plan_t       res_plan[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc_n = 0;

    always #5 clk = ~clk;

    fpu_cvt_wb_queue dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clk_en    (clk_en),
        .i_cvt_issue (cvt_issue),
        .i_cvt_reg   (cvt_reg),
        .i_cvt_ii    (cvt_ii),
        .i_cvt_res   (cvt_res),
        .i_cvt_alt   (cvt_alt),
        .i_flush     (flush),
        .i_wb_ready  (wb_ready),
        .o_wb_valid  (wb_valid),
        .o_wb_data   (wb_data),
        .o_wb_reg    (wb_reg),
        .o_wb_ii     (wb_ii),
        .o_wb_exc    (wb_exc),
        .o_cvt_stall (cvt_stall),
        .o_occ       (occ)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
        end
    endtask

    function automatic logic credit_ok();
        return (exp_q.size() + infl.size()) < DEPTH;
    endfunction

    task automatic plan(input logic [64:0] res, input logic alt);
        plan_t p;
        p.res = res;
        p.alt = alt;
        res_plan.push_back(p);
    endtask

    // One clock: drive at negedge, check, advance the model on posedge, return at next negedge.
    task automatic cyc(input logic iss, input logic [CVT_REGW-1:0] rg, input logic [CVT_IIW-1:0] ii,
                       input logic en, input logic rdy, input logic fl);
        logic        cap;
        logic        pop;
        plan_t       p;
        fifo_entry_t ent;
        op_t         op;
        cap = en && (infl.size() != 0) && (infl[0].n == LAT);
        pop = (exp_q.size() != 0) && rdy;
        if (cap && res_plan.size() != 0) begin
            p = res_plan.pop_front();
        end else begin
            p.res = {1'($urandom_range(0, 3) == 0), 32'($urandom), 32'($urandom)};
            p.alt = ($urandom_range(0, 3) == 0);
        end
        cvt_issue = iss;
        cvt_reg   = rg;
        cvt_ii    = ii;
        clk_en    = en;
        wb_ready  = rdy;
        flush     = fl;
        cvt_res   = p.res;
        cvt_alt   = p.alt;
        #1;
        chk("wb_valid", 64'(wb_valid), 64'(exp_q.size() != 0));
        chk("occ", 64'(occ), 64'(exp_q.size()));
        chk("cvt_stall", 64'(cvt_stall), 64'((exp_q.size() + infl.size() + int'(iss)) >= DEPTH));
        if (exp_q.size() != 0) begin
            chk("wb_data", wb_data, exp_q[0].data);
            chk("wb_reg", 64'(wb_reg), 64'(exp_q[0].dst_reg));
            chk("wb_ii", 64'(wb_ii), 64'(exp_q[0].ii));
            chk("wb_exc", 64'(wb_exc), 64'(exp_q[0].exc));
        end
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
            infl.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (cap) begin
                ent.data    = p.res[63:0];
                ent.dst_reg = infl[0].rg;
                ent.ii      = infl[0].ii;
                ent.exc     = p.res[64] | p.alt;
                exp_q.push_back(ent);
                void'(infl.pop_front());
            end
            if (en) begin
                foreach (infl[i]) infl[i].n = infl[i].n + 1;
                if (iss) begin
                    op.rg = rg;
                    op.ii = ii;
                    op.n  = 1;
                    infl.push_back(op);
                end
            end
        end
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, '0, '0, 1'b1, rdy, 1'b0);
    endtask

    task automatic rnd_issue(input logic iss, input logic en, input logic rdy, input logic fl);
        cyc(iss, CVT_REGW'($urandom), CVT_IIW'($urandom), en, rdy, fl);
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; cvt_issue = 1'b0; cvt_reg = '0; cvt_ii = '0;
        cvt_res = '0; cvt_alt = 1'b0; flush = 1'b0; wb_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(wb_valid), 64'(0));
        chk("rst_data", wb_data, 64'(0));
        chk("rst_reg", 64'(wb_reg), 64'(0));
        chk("rst_ii", 64'(wb_ii), 64'(0));
        chk("rst_exc", 64'(wb_exc), 64'(0));
        chk("rst_stall", 64'(cvt_stall), 64'(0));
        chk("rst_occ", 64'(occ), 64'(0));
        rst = 1'b0;

        // Single op: visible three cycles after issue.
        plan(65'h0_0000_0000_0000_007B, 1'b0);
        cyc(1'b1, 9'h02A, 10'd5, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 2);
        chk("single_valid", 64'(wb_valid), 64'(1));
        chk("single_data", wb_data, 64'h7B);
        chk("single_reg", 64'(wb_reg), 64'h2A);
        chk("single_ii", 64'(wb_ii), 64'd5);
        chk("single_exc", 64'(wb_exc), 64'(0));
        idle(1'b1, 2);
        chk("single_drained", 64'(wb_valid), 64'(0));

        // Exception tagging from bit 64 and from alt, in issue order.
        plan(65'h1_0000_0000_0000_0011, 1'b0);
        plan(65'h0_0000_0000_0000_0022, 1'b1);
        rnd_issue(1'b1, 1'b1, 1'b0, 1'b0);
        rnd_issue(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1);
        chk("exc1_data", wb_data, 64'h11);
        chk("exc1_exc", 64'(wb_exc), 64'(1));
        idle(1'b1, 1);
        chk("exc2_data", wb_data, 64'h22);
        chk("exc2_exc", 64'(wb_exc), 64'(1));
        idle(1'b1, 3);

        // Backpressure: issue whenever credit allows, nothing drains.
        for (int k = 0; k < 10; k++) rnd_issue(credit_ok(), 1'b1, 1'b0, 1'b0);
        chk("bp_occ", 64'(occ), 64'(4));
        chk("bp_stall", 64'(cvt_stall), 64'(1));
        idle(1'b1, 4);
        chk("bp_drain_occ", 64'(occ), 64'(0));
        chk("bp_drain_stall", 64'(cvt_stall), 64'(0));

        // clkEn freeze with a queued head still draining.
        rnd_issue(1'b1, 1'b1, 1'b0, 1'b0);
        rnd_issue(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 3);
        rnd_issue(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) rnd_issue(1'b0, 1'b0, 1'b1, 1'b0);
        chk("frz_popped", 64'(occ), 64'(0));
        idle(1'b1, 1);
        chk("frz_not_yet", 64'(wb_valid), 64'(0));
        idle(1'b0, 1);
        chk("frz_capture", 64'(wb_valid), 64'(1));
        idle(1'b1, 2);

        // Flush with 2 queued and 2 in flight, alongside issue and wb_ready.
        for (int k = 0; k < 4; k++) rnd_issue(1'b1, 1'b1, 1'b0, 1'b0);
        chk("fl_pre_occ", 64'(occ), 64'(2));
        rnd_issue(1'b1, 1'b1, 1'b1, 1'b1);
        chk("fl_valid", 64'(wb_valid), 64'(0));
        chk("fl_occ", 64'(occ), 64'(0));
        idle(1'b1, 4);
        chk("fl_nothing", 64'(occ), 64'(0));

        // Full buffer: one extra op forced past the stall lands on a pop cycle.
        for (int k = 0; k < 5; k++) rnd_issue(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1);
        chk("full_occ", 64'(occ), 64'(4));
        idle(1'b1, 1);
        chk("full_pushpop_occ", 64'(occ), 64'(4));
        idle(1'b1, 5);
        chk("full_drained", 64'(occ), 64'(0));

        // Random traffic respecting the issue credit.
        for (int k = 0; k < 600; k++) begin
            rnd_issue(credit_ok() && ($urandom_range(0, 2) != 0),
                      $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) != 0,
                      $urandom_range(0, 40) == 0);
        end
        idle(1'b1, 8);
        chk("end_empty", 64'(occ), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
